string_ntoa: RTL and testbench

Streaming unsigned-integer-to-ASCII formatter: accepts one DW-bit value per transaction and emits its text representation one character per handshake in decimal, hex, octal or binary, with optional leading-zero suppression and hex letter case control. It is the synthesizable counterpart of the `itoa`/`hextoa`/`octtoa`/`bintoa` string methods. It sits between numeric datapaths and byte-oriented text sinks such as UART or debug log FIFOs.

---
 rtl/string_ntoa_pkg.sv | 46 ++++
 rtl/string_ntoa_bin2bcd.sv | 75 +++++++
 rtl/string_ntoa.sv | 218 +++++++++++++++++++++
 tb/tb_string_ntoa.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/string_ntoa_pkg.sv
// Shared types and helpers for the string_ntoa formatter.
//   radix_t    : radix selector encoding (dec, hex, oct, bin)
//   state_t    : formatter FSM states
//   nd_dec/nd_hex/nd_oct : digit counts needed for a given value width
//   dig2ascii  : one 4-bit digit to its ASCII character
package string_ntoa_pkg;

    typedef enum logic [1:0] {
        DEC = 2'd0,
        HEX = 2'd1,
        OCT = 2'd2,
        BIN = 2'd3
    } radix_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // ceil(dw * log10(2)) using a 5-digit fixed-point approximation of log10(2)
    function automatic int nd_dec(input int dw);
        return (dw * 30103 + 99999) / 100000;
    endfunction

    function automatic int nd_hex(input int dw);
        return (dw + 3) / 4;
    endfunction

    function automatic int nd_oct(input int dw);
        return (dw + 2) / 3;
    endfunction

    function automatic logic [7:0] dig2ascii(input logic [3:0] d, input logic upc);
        logic [7:0] chr;
        if (d < 4'd10) begin
            chr = 8'h30 + {4'h0, d};
        end else if (upc) begin
            chr = 8'h41 + {4'h0, d} - 8'd10;
        end else begin
            chr = 8'h61 + {4'h0, d} - 8'd10;
        end
        return chr;
    endfunction

endpackage

// File: rtl/string_ntoa_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// The first shift step is taken on the start edge itself, so the BCD result
// is complete DW-1 clocks after start and done is high in the DW-th cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load din and begin conversion (single-cycle pulse)
//   din        : DW-bit unsigned value
//   done       : conversion finished, bcd valid (held until next start)
//   bcd        : ND packed BCD digits, digit 0 in bits [3:0]
module string_bin2bcd #(
    parameter int DW = 32,
    parameter int ND = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW-1:0]   din,
    output logic            done,
    output logic [4*ND-1:0] bcd
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0]   bin_r;
    logic [4*ND-1:0] bcd_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;
    logic            done_r;
    logic [4*ND-1:0] bcd_src_s;
    logic [4*ND-1:0] adj_s;
    logic [4*ND-1:0] bcd_nxt_s;
    logic            bit_src_s;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit
    always_comb begin
        bcd_src_s = start ? '0 : bcd_r;
        bit_src_s = start ? din[DW-1] : bin_r[DW-1];
        adj_s     = '0;
        for (int d = 0; d < ND; d++) begin
            adj_s[4*d +: 4] = (bcd_src_s[4*d +: 4] >= 4'd5) ? (bcd_src_s[4*d +: 4] + 4'd3)
                                                              : bcd_src_s[4*d +: 4];
        end
        bcd_nxt_s = {adj_s[4*ND-2:0], bit_src_s};
    end

    // Shift register, step counter and done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= '0;
            bcd_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            bin_r  <= {din[DW-2:0], 1'b0};
            bcd_r  <= bcd_nxt_s;
            cnt_r  <= CW'(1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r && !done_r) begin
            bin_r  <= {bin_r[DW-2:0], 1'b0};
            bcd_r  <= bcd_nxt_s;
            cnt_r  <= cnt_r + CW'(1);
            done_r <= (cnt_r == CW'(DW - 1));
        end else begin
            bin_r  <= bin_r;
            bcd_r  <= bcd_r;
            cnt_r  <= cnt_r;
            done_r <= done_r;
        end
    end

    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/string_ntoa.sv
// Streaming unsigned-integer-to-ASCII formatter (dec/hex/oct/bin).
// One value is accepted per transaction and emitted MSB digit first, one
// character per out_vld/out_rdy handshake, with optional leading-zero
// suppression and hex letter case selection.
//   in_vld/in_rdy/in_dat/in_rad/in_pad/in_upc : value input handshake
//   out_vld/out_rdy/out_chr/out_lst           : character output handshake
module string_ntoa
    import string_ntoa_pkg::*;
#(
    parameter int DW     = 32,
    parameter bit DEC_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_dat,
    input  logic [1:0]    in_rad,
    input  logic          in_pad,
    input  logic          in_upc,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [7:0]    out_chr,
    output logic          out_lst
);

    localparam int ND_DEC = nd_dec(DW);
    localparam int ND_HEX = nd_hex(DW);
    localparam int ND_OCT = nd_oct(DW);
    localparam int PW     = $clog2(DW);

    state_t          state_r;
    logic            in_rdy_r;
    logic            out_vld_r;
    logic            out_lst_r;
    logic [7:0]      out_chr_r;
    logic [PW-1:0]   pos_r;
    logic [DW-1:0]   val_r;
    radix_t          rad_r;
    logic            upc_r;
    logic            pad_r;

    radix_t          in_rad_s;
    logic            xfer_s;
    logic            conv_start_s;
    logic            conv_done_s;
    logic [4*ND_DEC-1:0] bcd_s;
    logic [DW-1:0]   src_val_s;
    radix_t          src_rad_s;
    logic            src_pad_s;
    logic            src_upc_s;
    logic [4*DW-1:0] ext_s;
    logic [4*DW-1:0] bcd_ext_s;
    logic [3:0]      dig_s [DW];
    logic [PW-1:0]   lead_s;
    logic [PW-1:0]   nd_last_s;
    logic [PW-1:0]   first_s;
    logic [PW-1:0]   nxt_pos_s;

    // Without the decimal converter, decimal requests fall back to hex
    always_comb begin
        if ((radix_t'(in_rad) == DEC) && !DEC_EN) begin
            in_rad_s = HEX;
        end else begin
            in_rad_s = radix_t'(in_rad);
        end
    end

    assign xfer_s       = in_vld && in_rdy_r;
    assign conv_start_s = xfer_s && (in_rad_s == DEC);

    generate
        if (DEC_EN) begin : g_dec
            string_bin2bcd #(
                .DW (DW),
                .ND (ND_DEC)
            ) u_bin2bcd (
                .clk   (clk),
                .rst_n (rst_n),
                .start (conv_start_s),
                .din   (in_dat),
                .done  (conv_done_s),
                .bcd   (bcd_s)
            );
        end else begin : g_nodec
            assign conv_done_s = 1'b0;
            assign bcd_s       = '0;
        end
    endgenerate

    // In IDLE the first character is formed straight from the input bus so
    // it can be registered on the accepting edge; afterwards use the captures
    always_comb begin
        if (state_r == ST_IDLE) begin
            src_val_s = in_dat;
            src_rad_s = in_rad_s;
            src_pad_s = in_pad;
            src_upc_s = in_upc;
        end else begin
            src_val_s = val_r;
            src_rad_s = rad_r;
            src_pad_s = pad_r;
            src_upc_s = upc_r;
        end
    end

    // Digit array; zero extension to 4*DW makes every digit beyond the
    // radix's digit count read as 0, so leading-zero search needs no bound
    always_comb begin
        ext_s                   = '0;
        ext_s[DW-1:0]           = src_val_s;
        bcd_ext_s               = '0;
        bcd_ext_s[4*ND_DEC-1:0] = bcd_s;
        for (int i = 0; i < DW; i++) begin
            case (src_rad_s)
                DEC:     dig_s[i] = bcd_ext_s[4*i +: 4];
                HEX:     dig_s[i] = ext_s[4*i +: 4];
                OCT:     dig_s[i] = {1'b0, ext_s[3*i +: 3]};
                BIN:     dig_s[i] = {3'b000, ext_s[i]};
                default: dig_s[i] = 4'd0;
            endcase
        end
    end

    // Most significant nonzero digit index (0 for a zero value)
    always_comb begin
        lead_s = '0;
        for (int i = 0; i < DW; i++) begin
            lead_s = (dig_s[i] != 4'd0) ? PW'(i) : lead_s;
        end
    end

    // Index of the top digit in padded mode
    always_comb begin
        case (src_rad_s)
            DEC:     nd_last_s = PW'(ND_DEC - 1);
            HEX:     nd_last_s = PW'(ND_HEX - 1);
            OCT:     nd_last_s = PW'(ND_OCT - 1);
            BIN:     nd_last_s = PW'(DW - 1);
            default: nd_last_s = PW'(ND_HEX - 1);
        endcase
    end

    assign first_s   = src_pad_s ? nd_last_s : lead_s;
    assign nxt_pos_s = pos_r - PW'(1);

    // Formatter FSM with capture and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            in_rdy_r  <= 1'b1;
            out_vld_r <= 1'b0;
            out_chr_r <= 8'h00;
            out_lst_r <= 1'b0;
            pos_r     <= '0;
            val_r     <= '0;
            rad_r     <= HEX;
            upc_r     <= 1'b0;
            pad_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        val_r    <= in_dat;
                        rad_r    <= in_rad_s;
                        upc_r    <= in_upc;
                        pad_r    <= in_pad;
                        in_rdy_r <= 1'b0;
                        if (in_rad_s == DEC) begin
                            state_r <= ST_CONV;
                        end else begin
                            state_r   <= ST_EMIT;
                            out_vld_r <= 1'b1;
                            out_chr_r <= dig2ascii(dig_s[first_s], src_upc_s);
                            out_lst_r <= (first_s == PW'(0));
                            pos_r     <= first_s;
                        end
                    end
                end
                ST_CONV: begin
                    if (conv_done_s) begin
                        state_r   <= ST_EMIT;
                        out_vld_r <= 1'b1;
                        out_chr_r <= dig2ascii(dig_s[first_s], src_upc_s);
                        out_lst_r <= (first_s == PW'(0));
                        pos_r     <= first_s;
                    end
                end
                ST_EMIT: begin
                    if (out_rdy) begin
                        if (out_lst_r) begin
                            state_r   <= ST_IDLE;
                            in_rdy_r  <= 1'b1;
                            out_vld_r <= 1'b0;
                            out_lst_r <= 1'b0;
                        end else begin
                            pos_r     <= nxt_pos_s;
                            out_chr_r <= dig2ascii(dig_s[nxt_pos_s], src_upc_s);
                            out_lst_r <= (nxt_pos_s == PW'(0));
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    in_rdy_r  <= 1'b1;
                    out_vld_r <= 1'b0;
                    out_lst_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_rdy  = in_rdy_r;
    assign out_vld = out_vld_r;
    assign out_chr = out_chr_r;
    assign out_lst = out_lst_r;

endmodule

// File: tb/tb_string_ntoa.sv
// Self-checking bench for string_ntoa (DW=32, DEC_EN=1).
// Expected strings come from repeated division by the radix.
module tb_string_ntoa;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_dat = '0;
    logic [1:0]    in_rad = 2'd0;
    logic          in_pad = 1'b0;
    logic          in_upc = 1'b0;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [7:0]    out_chr;
    logic          out_lst;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    string_ntoa #(.DW(DW), .DEC_EN(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_dat  (in_dat),
        .in_rad  (in_rad),
        .in_pad  (in_pad),
        .in_upc  (in_upc),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_chr (out_chr),
        .out_lst (out_lst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: digits by repeated division, then optional zero stripping
    task automatic build_exp(input logic [31:0] v, input logic [1:0] r,
                             input logic pad, input logic upc);
        longint unsigned x;
        int base;
        int nd;
        int digs[$];
        x = 64'(v);
        case (r)
            2'd0:    begin base = 10; nd = 10; end
            2'd1:    begin base = 16; nd = 8;  end
            2'd2:    begin base = 8;  nd = 11; end
            default: begin base = 2;  nd = 32; end
        endcase
        exp_q.delete();
        for (int i = 0; i < nd; i++) begin
            digs.push_front(int'(x % longint'(base)));
            x = x / longint'(base);
        end
        if (!pad) begin
            while (digs.size() > 1 && digs[0] == 0) void'(digs.pop_front());
        end
        foreach (digs[i]) begin
            if (digs[i] < 10) exp_q.push_back(8'(48 + digs[i]));
            else              exp_q.push_back(8'((upc ? 65 : 97) + digs[i] - 10));
        end
    endtask

    // One transaction; abort_at>0 pulls reset at that cycle after accept
    task automatic run(input logic [31:0] v, input logic [1:0] r, input logic pad,
                       input logic upc, input logic bp, input int abort_at);
        int k;
        int exp_lat;
        bit first_seen;
        bit stall;
        bit done;
        logic [7:0] hc;
        logic hl;
        build_exp(v, r, pad, upc);
        got_q.delete();
        exp_lat = (r == 2'd0) ? DW + 1 : 1;
        k = 0;
        while (!in_rdy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rdy_wait", 64'(in_rdy), 64'd1);
        if (!in_rdy) return;
        in_vld = 1'b1; in_dat = v; in_rad = r; in_pad = pad; in_upc = upc;
        @(negedge clk);
        in_vld = 1'b0; in_dat = $urandom; in_rad = 2'($urandom); in_pad = 1'($urandom); in_upc = 1'($urandom);
        first_seen = 0; stall = 0; done = 0; hc = 8'h00; hl = 1'b0;
        for (k = 1; k <= 400 && !done; k++) begin
            if (abort_at != 0 && k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_in_rdy", 64'(in_rdy), 64'd1);
                chk("rst_out_vld", 64'(out_vld), 64'd0);
                chk("rst_out_chr", 64'(out_chr), 64'd0);
                chk("rst_out_lst", 64'(out_lst), 64'd0);
                out_rdy = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (stall) begin
                chk("hold_vld", 64'(out_vld), 64'd1);
                chk("hold_chr", 64'(out_chr), 64'(hc));
                chk("hold_lst", 64'(out_lst), 64'(hl));
            end
            chk("busy_in_rdy", 64'(in_rdy), 64'd0);
            if (out_vld && !first_seen) begin
                first_seen = 1;
                chk("latency", 64'(k), 64'(exp_lat));
            end
            out_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = out_vld && !out_rdy;
            hc = out_chr;
            hl = out_lst;
            if (out_vld && out_rdy) begin
                got_q.push_back(out_chr);
                if (out_lst) done = 1;
            end
            @(negedge clk);
        end
        out_rdy = 1'b0;
        chk("finished", 64'(done), 64'd1);
        chk("length", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk("char", 64'(got_q[i]), 64'(exp_q[i]));
        end
        chk("rdy_after", 64'(in_rdy), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_in_rdy", 64'(in_rdy), 64'd1);
        chk("reset_out_vld", 64'(out_vld), 64'd0);
        chk("reset_out_chr", 64'(out_chr), 64'd0);
        chk("reset_out_lst", 64'(out_lst), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'hDEADBEEF, 2'd1, 1'b0, 1'b1, 1'b0, 0);
        run(32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b0, 0);
        run(32'd356,      2'd0, 1'b0, 1'b0, 1'b0, 0);
        run(32'd13,       2'd0, 1'b1, 1'b0, 1'b0, 0);
        run(32'd356,      2'd2, 1'b0, 1'b0, 1'b0, 0);
        run(32'hA5,       2'd3, 1'b0, 1'b0, 1'b0, 0);
        run(32'hA5,       2'd3, 1'b1, 1'b0, 1'b0, 0);
        for (int r = 0; r < 4; r++) run(32'd0, 2'(r), 1'b0, 1'b0, 1'b0, 0);
        run(32'hFFFFFFFF, 2'd0, 1'b0, 1'b0, 1'b0, 0);
        run(32'h3031,     2'd1, 1'b0, 1'b0, 1'b1, 0);
        run(32'd123456,   2'd0, 1'b0, 1'b0, 1'b0, 10);
        run(32'hA5,       2'd3, 1'b1, 1'b0, 1'b0, 6);
        run(32'h7,        2'd1, 1'b0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0:       v = 32'($urandom_range(0, 20));
                1:       v = 32'hFFFFFFFF >> $urandom_range(0, 31);
                default: v = $urandom;
            endcase
            run(v, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
